sparse_mac_accum: RTL and testbench

SPARSE_MAC_ACCUM -- requirements
Module: sparse_mac_accum

---
 rtl/sparse_mac_pkg.sv | 16 +
 rtl/sparse_mac_accum_if.sv | 27 ++
 rtl/sparse_mac_mul_add.sv | 89 ++++++++
 rtl/sparse_mac_accum.sv | 105 ++++++++++
 tb/tb_sparse_mac_accum.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sparse_mac_pkg.sv
// Shared widths, operand type and accumulator FSM encoding for the sparse dot-product MAC.
package sparse_mac_pkg;

    localparam int VALUE_W       = 8;
    localparam int ACC_W_DEFAULT = 32;

    typedef logic signed [VALUE_W-1:0] value_bus_t;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_RESULT = 2'd2,
        ST_DONE   = 2'd3
    } acc_state_e;

endpackage

// File: rtl/sparse_mac_accum_if.sv
// Matched-pair input stream and dot-product result port of the sparse MAC.
interface sparse_mac_accum_if #(
    parameter int VALUE_W = sparse_mac_pkg::VALUE_W,
    parameter int ACC_W   = sparse_mac_pkg::ACC_W_DEFAULT,
    parameter int CNT_W   = 16
);
    logic                     mac_valid_i;
    logic                     mac_finish_i;
    logic [1:0][VALUE_W-1:0]  mac_data_i;
    logic                     clear_i;
    logic                     result_valid_o;
    logic                     result_ready_i;
    logic [ACC_W-1:0]         result_data_o;
    logic [CNT_W-1:0]         match_count_o;
    logic                     overflow_o;
    logic                     busy_o;

    modport slave (
        input  mac_valid_i, mac_finish_i, mac_data_i, clear_i, result_ready_i,
        output result_valid_o, result_data_o, match_count_o, overflow_o, busy_o
    );

    modport master (
        output mac_valid_i, mac_finish_i, mac_data_i, clear_i, result_ready_i,
        input  result_valid_o, result_data_o, match_count_o, overflow_o, busy_o
    );
endinterface

// File: rtl/sparse_mac_mul_add.sv
// Two-stage multiply / accumulate datapath: product register, sign-extended addend register, acc.
// Define SPARSE_MAC_ACC_SAT_EN for a saturating accumulator with sticky overflow; default wraps.
module sparse_mac_mul_add #(
    parameter int VALUE_W = sparse_mac_pkg::VALUE_W,
    parameter int ACC_W   = sparse_mac_pkg::ACC_W_DEFAULT
) (
    input  logic                      mac_clk,
    input  logic                      mac_rst,
    input  logic                      i_clear,
    input  logic                      i_accept,
    input  logic signed [VALUE_W-1:0] i_lhs,
    input  logic signed [VALUE_W-1:0] i_rhs,
    output logic signed [ACC_W-1:0]   o_acc,
    output logic                      o_s1_valid,
    output logic                      o_s2_valid,
    output logic                      o_overflow
);
    logic signed [2*VALUE_W-1:0] w_prod;
    logic signed [2*VALUE_W-1:0] r_prod;
    logic signed [ACC_W-1:0]     r_addend;
    logic signed [ACC_W-1:0]     r_acc;
    logic signed [ACC_W-1:0]     w_acc_next;
    logic                        r_s1_valid;
    logic                        r_s2_valid;

    assign w_prod = (2*VALUE_W)'(i_lhs) * (2*VALUE_W)'(i_rhs);

`ifdef SPARSE_MAC_ACC_SAT_EN
    logic signed [ACC_W:0] w_sum;
    logic                  w_ovf;
    logic                  r_overflow;

    // One guard bit: the two top sum bits disagree exactly when the signed add left the range.
    always_comb begin
        w_sum = {r_acc[ACC_W-1], r_acc} + {r_addend[ACC_W-1], r_addend};
        w_ovf = w_sum[ACC_W] != w_sum[ACC_W-1];
        if (w_ovf) begin
            w_acc_next = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            w_acc_next = w_sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge mac_clk or negedge mac_rst) begin
        if (!mac_rst) begin
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_overflow <= 1'b0;
        end else if (r_s2_valid && w_ovf) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_overflow = r_overflow;
`else
    assign w_acc_next = r_acc + r_addend;
    assign o_overflow = 1'b0;
`endif

    always_ff @(posedge mac_clk or negedge mac_rst) begin
        if (!mac_rst) begin
            r_prod     <= '0;
            r_addend   <= '0;
            r_acc      <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (i_clear) begin
            r_acc      <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= i_accept;
            r_s2_valid <= r_s1_valid;
            if (i_accept) begin
                r_prod <= w_prod;
            end
            if (r_s1_valid) begin
                r_addend <= ACC_W'(r_prod);
            end
            if (r_s2_valid) begin
                r_acc <= w_acc_next;
            end
        end
    end

    assign o_acc      = r_acc;
    assign o_s1_valid = r_s1_valid;
    assign o_s2_valid = r_s2_valid;
endmodule

// File: rtl/sparse_mac_accum.sv
// Sparse dot-product accumulator: run FSM, saturating match counter and result port.
// Optional saturating accumulate via SPARSE_MAC_ACC_SAT_EN (see sparse_mac_mul_add).
//   state     | meaning
//   ST_ACCUM  | accepting matched pairs until finish
//   ST_DRAIN  | inputs ignored, pipeline emptying into acc
//   ST_RESULT | result_valid_o high, waiting for result_ready_i
//   ST_DONE   | idle, everything ignored except clear_i
module sparse_mac_accum #(
    parameter int VALUE_W = sparse_mac_pkg::VALUE_W,
    parameter int ACC_W   = sparse_mac_pkg::ACC_W_DEFAULT,
    parameter int CNT_W   = 16
) (
    input logic               mac_clk,
    input logic               mac_rst,
    sparse_mac_accum_if.slave bus
);
    import sparse_mac_pkg::*;

    if (ACC_W < 2*VALUE_W) begin : g_acc_w_check
        $error("sparse_mac_accum: ACC_W must be at least 2*VALUE_W");
    end

    acc_state_e              r_state;
    acc_state_e              w_state_next;
    logic                    w_accept;
    logic signed [ACC_W-1:0] w_acc;
    logic                    w_s1_valid;
    logic                    w_s2_valid;
    logic                    w_overflow;
    logic [CNT_W-1:0]        r_match_count;

    sparse_mac_mul_add #(
        .VALUE_W (VALUE_W),
        .ACC_W   (ACC_W)
    ) u_mul_add (
        .mac_clk    (mac_clk),
        .mac_rst    (mac_rst),
        .i_clear    (bus.clear_i),
        .i_accept   (w_accept),
        .i_lhs      (bus.mac_data_i[0]),
        .i_rhs      (bus.mac_data_i[1]),
        .o_acc      (w_acc),
        .o_s1_valid (w_s1_valid),
        .o_s2_valid (w_s2_valid),
        .o_overflow (w_overflow)
    );

    always_ff @(posedge mac_clk or negedge mac_rst) begin
        if (!mac_rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Leaving DRAIN once stage 1 is empty is safe: any stage-2 add lands on that same edge.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        unique case (r_state)
            ST_ACCUM: begin
                w_accept = bus.mac_valid_i;
                if (bus.mac_finish_i) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!w_s1_valid) begin
                    w_state_next = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (bus.result_ready_i) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_DONE;
            end
            default: begin
                w_state_next = ST_ACCUM;
            end
        endcase
        if (bus.clear_i) begin
            w_state_next = ST_ACCUM;
            w_accept     = 1'b0;
        end
    end

    always_ff @(posedge mac_clk or negedge mac_rst) begin
        if (!mac_rst) begin
            r_match_count <= '0;
        end else if (bus.clear_i) begin
            r_match_count <= '0;
        end else if (w_s2_valid && (r_match_count != {CNT_W{1'b1}})) begin
            r_match_count <= r_match_count + CNT_W'(1);
        end
    end

    assign bus.result_valid_o = (r_state == ST_RESULT);
    assign bus.result_data_o  = (r_state == ST_RESULT) ? w_acc : '0;
    assign bus.match_count_o  = r_match_count;
    assign bus.overflow_o     = w_overflow;
    assign bus.busy_o         = (r_state != ST_DONE);
endmodule

// File: tb/tb_sparse_mac_accum.sv
// Bench for sparse_mac_accum: a 32-bit and a 16-bit accumulator instance share one stimulus
// stream and are compared against a pair-list dot-product model (honours SPARSE_MAC_ACC_SAT_EN).
module tb_sparse_mac_accum;

    logic mac_clk = 1'b0;
    logic mac_rst;
    always #5 mac_clk = ~mac_clk;

    logic valid, finish, clear, ready;
    sparse_mac_pkg::value_bus_t lhs, rhs;

    sparse_mac_accum_if #(.VALUE_W(8), .ACC_W(32), .CNT_W(16)) bus32 ();
    sparse_mac_accum_if #(.VALUE_W(8), .ACC_W(16), .CNT_W(16)) bus16 ();

    assign bus32.mac_valid_i    = valid;
    assign bus32.mac_finish_i   = finish;
    assign bus32.clear_i        = clear;
    assign bus32.result_ready_i = ready;
    assign bus32.mac_data_i     = {rhs, lhs};
    assign bus16.mac_valid_i    = valid;
    assign bus16.mac_finish_i   = finish;
    assign bus16.clear_i        = clear;
    assign bus16.result_ready_i = ready;
    assign bus16.mac_data_i     = {rhs, lhs};

    sparse_mac_accum #(.VALUE_W(8), .ACC_W(32), .CNT_W(16)) u_dut32 (
        .mac_clk (mac_clk),
        .mac_rst (mac_rst),
        .bus     (bus32.slave)
    );

    sparse_mac_accum #(.VALUE_W(8), .ACC_W(16), .CNT_W(16)) u_dut16 (
        .mac_clk (mac_clk),
        .mac_rst (mac_rst),
        .bus     (bus16.slave)
    );

    int errors = 0;
    int checks = 0;
    int q_lhs[$];
    int q_rhs[$];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mac_clk);
        #1;
    endtask

    // Reference: plain sum of the pairs of the current run, clamped per add or wrapped to w bits.
    function automatic longint model_acc(input int w, output bit ovf);
        longint acc = 0;
        longint hi = (longint'(1) <<< (w-1)) - 1;
        longint lo = -(longint'(1) <<< (w-1));
        longint m  = longint'(1) <<< w;
        ovf = 1'b0;
        foreach (q_lhs[i]) begin
            acc += longint'(q_lhs[i] * q_rhs[i]);
`ifdef SPARSE_MAC_ACC_SAT_EN
            if (acc > hi) begin
                acc = hi;
                ovf = 1'b1;
            end else if (acc < lo) begin
                acc = lo;
                ovf = 1'b1;
            end
`endif
        end
`ifndef SPARSE_MAC_ACC_SAT_EN
        acc = acc & (m - 1);
        if (acc > hi) acc -= m;
`endif
        return acc;
    endfunction

    function automatic int model_count();
        return (q_lhs.size() > 65535) ? 65535 : q_lhs.size();
    endfunction

    task automatic push_fin(input int a, input int b, input bit fin);
        valid  = 1'b1;
        finish = fin;
        lhs    = 8'(a);
        rhs    = 8'(b);
        q_lhs.push_back(a);
        q_rhs.push_back(b);
        tick();
        valid  = 1'b0;
        finish = 1'b0;
    endtask

    task automatic push(input int a, input int b);
        push_fin(a, b, 1'b0);
    endtask

    task automatic finish_run();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    task automatic start_run();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        q_lhs.delete();
        q_rhs.delete();
    endtask

    task automatic check_result(input string tag, input int hold);
        bit     o32, o16;
        longint e32, e16;
        int     n;
        e32 = model_acc(32, o32);
        e16 = model_acc(16, o16);
        n = 0;
        while (bus32.result_valid_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ":rv_timeout"}, bus32.result_valid_o, 1);
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) tick();
            chk({tag, ":rv16"}, bus16.result_valid_o, 1);
            chk({tag, ":data32"}, $signed(bus32.result_data_o), e32);
            chk({tag, ":data16"}, $signed(bus16.result_data_o), e16);
        end
        chk({tag, ":count32"}, bus32.match_count_o, model_count());
        chk({tag, ":count16"}, bus16.match_count_o, model_count());
        chk({tag, ":ovf32"}, bus32.overflow_o, o32);
        chk({tag, ":ovf16"}, bus16.overflow_o, o16);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk({tag, ":done_busy"}, bus32.busy_o, 0);
        chk({tag, ":done_rv"}, bus32.result_valid_o, 0);
        chk({tag, ":done_data"}, bus32.result_data_o, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ":busy"}, bus32.busy_o, 1);
        chk({tag, ":rv"}, bus32.result_valid_o, 0);
        chk({tag, ":data"}, bus32.result_data_o, 0);
        chk({tag, ":count"}, bus32.match_count_o, 0);
        chk({tag, ":ovf"}, bus32.overflow_o, 0);
        chk({tag, ":count16"}, bus16.match_count_o, 0);
        chk({tag, ":ovf16"}, bus16.overflow_o, 0);
    endtask

    initial begin
        int k, a, b, hold;
        bit fin_with;

        mac_rst = 1'b0;
        valid = 1'b0; finish = 1'b0; clear = 1'b0; ready = 1'b0;
        lhs = '0; rhs = '0;
        tick();
        tick();
        chk_reset_outputs("reset");
        mac_rst = 1'b1;
        tick();

        // (3,4),(-2,5),(7,7) -> 51
        push(3, 4);
        push(-2, 5);
        push(7, 7);
        finish_run();
        chk("basic:model51", model_acc(32, fin_with), 51);
        check_result("basic", 0);

        // DONE ignores pairs and finish until clear
        valid = 1'b1; lhs = 8'(10); rhs = 8'(10); finish = 1'b1;
        tick(); tick(); tick();
        valid = 1'b0; finish = 1'b0;
        tick(); tick(); tick();
        chk("done_ignore:busy", bus32.busy_o, 0);
        chk("done_ignore:rv", bus32.result_valid_o, 0);
        chk("done_ignore:count", bus32.match_count_o, 3);

        // result held while ready is low
        start_run();
        push(-7, 9);
        push(12, -11);
        push(100, 3);
        finish_run();
        check_result("hold10", 10);

        // zero matches: valid 2 cycles after finish
        start_run();
        finish_run();
        chk("zero:rv_at1", bus32.result_valid_o, 0);
        tick();
        chk("zero:rv_at2", bus32.result_valid_o, 1);
        chk("zero:data", bus32.result_data_o, 0);
        chk("zero:count", bus32.match_count_o, 0);
        check_result("zero", 0);

        // pair in the finish cycle: two DRAIN cycles
        start_run();
        push_fin(6, -3, 1'b1);
        tick();
        chk("fin_pair:rv_at2", bus32.result_valid_o, 0);
        tick();
        chk("fin_pair:rv_at3", bus32.result_valid_o, 1);
        chk("fin_pair:data", $signed(bus32.result_data_o), -18);
        check_result("fin_pair", 0);

        // accepted pair visible in count at end of N+2
        start_run();
        push(2, 3);
        tick();
        chk("latency:count_n1", bus32.match_count_o, 0);
        tick();
        chk("latency:count_n2", bus32.match_count_o, 1);
        finish_run();
        check_result("latency", 0);

        // clear coincident with a pair mid-run
        start_run();
        push(1, 2);
        push(3, 3);
        clear = 1'b1; valid = 1'b1; lhs = 8'(5); rhs = 8'(5);
        tick();
        clear = 1'b0; valid = 1'b0;
        q_lhs.delete();
        q_rhs.delete();
        chk("clear_mid:count0", bus32.match_count_o, 0);
        tick(); tick(); tick();
        chk("clear_mid:count_late", bus32.match_count_o, 0);
        chk("clear_mid:busy", bus32.busy_o, 1);
        push(2, 2);
        finish_run();
        check_result("clear_mid", 0);

        // 16-bit accumulator overflow
        start_run();
        push(127, 127);
        push(127, 127);
        push(127, 127);
        finish_run();
`ifdef SPARSE_MAC_ACC_SAT_EN
        chk("ovf16:model", model_acc(16, fin_with), 32767);
`else
        chk("ovf16:model", model_acc(16, fin_with), -17149);
`endif
        check_result("ovf16", 0);

        // reset with two pairs in flight
        start_run();
        push(9, 9);
        push(8, 8);
        mac_rst = 1'b0;
        #2;
        chk_reset_outputs("rst_mid");
        tick();
        chk_reset_outputs("rst_mid_hold");
        mac_rst = 1'b1;
        q_lhs.delete();
        q_rhs.delete();
        push(1, 1);
        finish_run();
        check_result("rst_mid_run", 0);

        // randomized runs
        for (int r = 0; r < 20; r++) begin
            k        = $urandom_range(0, 6);
            fin_with = 1'($urandom_range(0, 1));
            hold     = $urandom_range(0, 3);
            start_run();
            for (int p = 0; p < k; p++) begin
                if ($urandom_range(0, 2) == 0) tick();
                a = int'($urandom_range(0, 255)) - 128;
                b = int'($urandom_range(0, 255)) - 128;
                push_fin(a, b, (p == k - 1) && fin_with);
            end
            if (!(k > 0 && fin_with)) finish_run();
            check_result("rand", hold);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
